// File: rtl/cond_branch_pkg.sv
// Shared types for the branch-resolution slice: branch kinds, condition codes,
// stall FSM states and the zero-register number.
package cond_branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE  = 2'd0,
    BR_B     = 2'd1,
    BR_BCOND = 2'd2,
    BR_CBZ   = 2'd3
  } br_type_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: decides whether a condition code holds
// for a given {N,Z,C,V} flag vector.
module cond_eval
  import cond_branch_pkg::*;
(
  input  logic [3:0] flags,
  input  cond_t      cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_HS: pass = c;
      COND_LO: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !(c & !z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = !(!z & (n == v));
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Decode-stage branch resolver with NZCV register, EX flag forwarding and a
// one-cycle CBZ load-use stall. Optional counters under BRANCH_STATS_EN.
module cond_branch_unit
  import cond_branch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_flags,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic [1:0]        dec_br_type,
  input  logic [3:0]        dec_cond,
  input  logic [4:0]        dec_rt,
  input  logic [DATA_W-1:0] dec_rt_data,
  output logic              br_taken,
  output logic              stall,
  output logic [3:0]        flags_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
`endif
);

  state_t     state, state_nxt;
  br_type_t   br_type;
  logic [3:0] eff_flags;
  logic       cond_pass;
  logic       rt_zero;
  logic       haz;
  logic       resolved;

  assign br_type   = br_type_t'(dec_br_type);
  assign eff_flags = ex_set_flags ? ex_flags : flags_q;
  assign rt_zero   = (dec_rt_data == '0);

  // XZR never has a producer, so a load "writing" it cannot create a hazard.
  assign haz = (br_type == BR_CBZ) && ex_is_load && (ex_rd == dec_rt) && (dec_rt != XZR);

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (cond_t'(dec_cond)),
    .pass  (cond_pass)
  );

  always_comb begin
    resolved = 1'b0;
    case (br_type)
      BR_B:     resolved = 1'b1;
      BR_BCOND: resolved = cond_pass;
      BR_CBZ:   resolved = rt_zero;
      default:  resolved = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    br_taken  = 1'b0;
    stall     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (haz) begin
            stall     = 1'b1;
            state_nxt = STALL;
          end else begin
            br_taken = resolved;
          end
        end
        STALL: begin
          br_taken  = resolved;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      flags_q <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (ex_set_flags) flags_q <= ex_flags;
    end
  end

`ifdef BRANCH_STATS_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if ((br_type != BR_NONE) && !stall && (br_count != '1))
        br_count <= br_count + 1'b1;
      if (br_taken && (taken_count != '1))
        taken_count <= taken_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: directed vector table, a stats
// sequence (BRANCH_STATS_EN) and randomized cycles against a reference model.
module tb_cond_branch_unit;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_set_flags;
  logic [3:0]        ex_flags;
  logic              ex_is_load;
  logic [4:0]        ex_rd;
  logic [1:0]        dec_br_type;
  logic [3:0]        dec_cond;
  logic [4:0]        dec_rt;
  logic [DATA_W-1:0] dec_rt_data;
  logic              br_taken;
  logic              stall;
  logic [3:0]        flags_q;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;
`endif

  cond_branch_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_set_flags (ex_set_flags),
    .ex_flags     (ex_flags),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .dec_br_type  (dec_br_type),
    .dec_cond     (dec_cond),
    .dec_rt       (dec_rt),
    .dec_rt_data  (dec_rt_data),
    .br_taken     (br_taken),
    .stall        (stall),
    .flags_q      (flags_q)
`ifdef BRANCH_STATS_EN
    ,
    .br_count     (br_count),
    .taken_count  (taken_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              sf;
    logic [3:0]        fl;
    logic              ld;
    logic [4:0]        rd;
    logic [1:0]        bt;
    logic [3:0]        cd;
    logic [4:0]        rt;
    logic [DATA_W-1:0] dt;
    logic              e_tk;
    logic              e_st;
    logic [3:0]        e_fq;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: architectural flags, "previous cycle stalled", counters.
  logic [3:0]  m_flags = 4'b0000;
  bit          m_stalled = 1'b0;
  longint      m_br_cnt = 0;
  longint      m_tk_cnt = 0;
  logic        m_exp_tk, m_exp_st;
  logic        s_tk, s_st;

  function automatic bit cond_holds(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, samples outputs at the falling edge, advances the model
  // at the rising edge and leaves time just past it.
  task automatic applyStimulus(input vec_t v);
    logic [3:0] eff;
    bit hazard;
    reset        = v.rst;
    ex_set_flags = v.sf;
    ex_flags     = v.fl;
    ex_is_load   = v.ld;
    ex_rd        = v.rd;
    dec_br_type  = v.bt;
    dec_cond     = v.cd;
    dec_rt       = v.rt;
    dec_rt_data  = v.dt;

    eff    = v.sf ? v.fl : m_flags;
    hazard = (v.bt == 2'd3) && v.ld && (v.rd == v.rt) && (v.rt != 5'd31);
    m_exp_st = !v.rst && !m_stalled && hazard;
    m_exp_tk = 1'b0;
    if (!v.rst && !m_exp_st) begin
      if (v.bt == 2'd1) m_exp_tk = 1'b1;
      else if (v.bt == 2'd2) m_exp_tk = cond_holds(eff, v.cd);
      else if (v.bt == 2'd3) m_exp_tk = (v.dt == 0);
    end

    @(negedge clk);
    s_tk = br_taken;
    s_st = stall;
    @(posedge clk);
    if (v.rst) begin
      m_flags = 4'b0000; m_stalled = 1'b0; m_br_cnt = 0; m_tk_cnt = 0;
    end else begin
      m_stalled = m_exp_st;
      if (v.sf) m_flags = v.fl;
      if (v.bt != 2'd0 && !m_exp_st) m_br_cnt++;
      if (m_exp_tk) m_tk_cnt++;
    end
    #1;
  endtask

  vec_t vecs[23];

  initial begin
    // rst sf fl ld rd bt cd rt dt | tk st fq
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 2'd0, 4'h0, 5'd0, 64'd0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'hF, 1'b0, 5'd0, 2'd0, 4'h0, 5'd0, 64'd0, 1'b0, 1'b0, 4'hF};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 2'd1, 4'h0, 5'd0, 64'd0, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd0, 4'h0, 5'd0, 64'd0, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'h4, 1'b0, 5'd0, 2'd2, 4'h0, 5'd0, 64'd0, 1'b1, 1'b0, 4'h4};
    vecs[5]  = '{1'b0, 1'b1, 4'h8, 1'b0, 5'd0, 2'd0, 4'h0, 5'd0, 64'd0, 1'b0, 1'b0, 4'h8};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd2, 4'hA, 5'd0, 64'd0, 1'b0, 1'b0, 4'h8};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd2, 4'hB, 5'd0, 64'd0, 1'b1, 1'b0, 4'h8};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd5, 2'd3, 4'h0, 5'd5, 64'd1234, 1'b0, 1'b1, 4'h8};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd5, 2'd3, 4'h0, 5'd5, 64'd0, 1'b1, 1'b0, 4'h8};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd31, 2'd3, 4'h0, 5'd31, 64'd0, 1'b1, 1'b0, 4'h8};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd31, 2'd3, 4'h0, 5'd31, 64'd5, 1'b0, 1'b0, 4'h8};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd7, 2'd3, 4'h0, 5'd7, 64'd0, 1'b0, 1'b1, 4'h8};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 1'b0, 5'd7, 2'd3, 4'h0, 5'd7, 64'd0, 1'b0, 1'b0, 4'h0};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd7, 2'd3, 4'h0, 5'd7, 64'd0, 1'b0, 1'b1, 4'h0};
    vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd3, 4'h0, 5'd7, 64'd0, 1'b1, 1'b0, 4'h0};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 1'b1, 5'd3, 2'd3, 4'h0, 5'd3, 64'd0, 1'b0, 1'b1, 4'h0};
    vecs[17] = '{1'b0, 1'b1, 4'h3, 1'b0, 5'd0, 2'd3, 4'h0, 5'd3, 64'd1, 1'b0, 1'b0, 4'h3};
    vecs[18] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd1, 4'h0, 5'd0, 64'd9, 1'b1, 1'b0, 4'h3};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd2, 4'h8, 5'd0, 64'd0, 1'b1, 1'b0, 4'h3};
    vecs[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd2, 4'hE, 5'd0, 64'd0, 1'b1, 1'b0, 4'h3};
    vecs[21] = '{1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 2'd2, 4'hF, 5'd0, 64'd0, 1'b1, 1'b0, 4'h3};
    vecs[22] = '{1'b0, 1'b1, 4'h4, 1'b0, 5'd0, 2'd2, 4'hD, 5'd0, 64'd0, 1'b1, 1'b0, 4'h4};

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d br_taken", i), 64'(s_tk), 64'(vecs[i].e_tk));
      checkOutput($sformatf("vec%0d stall", i), 64'(s_st), 64'(vecs[i].e_st));
      checkOutput($sformatf("vec%0d flags_q", i), 64'(flags_q), 64'(vecs[i].e_fq));
    end

`ifdef BRANCH_STATS_EN
    begin
      vec_t sv;
      sv = '{1'b1, 1'b0, 4'h0, 1'b0, 5'd0, 2'd0, 4'h0, 5'd0, 64'd0, 1'b0, 1'b0, 4'h0};
      applyStimulus(sv);
      sv.rst = 1'b0; sv.bt = 2'd1;
      applyStimulus(sv);
      sv.bt = 2'd3; sv.rt = 5'd4; sv.dt = 64'd5;
      applyStimulus(sv);
      sv.dt = 64'd0;
      applyStimulus(sv);
      checkOutput("stats br_count", 64'(br_count), 64'd3);
      checkOutput("stats taken_count", 64'(taken_count), 64'd2);
    end
`endif

    // Randomized phase: small register set to make hazards and XZR frequent.
    for (int i = 0; i < 400; i++) begin
      vec_t rv;
      logic [4:0] regs [3];
      regs[0] = 5'd3; regs[1] = 5'd5; regs[2] = 5'd31;
      rv.rst  = ($urandom_range(31) == 0);
      rv.sf   = $urandom_range(1);
      rv.fl   = 4'($urandom);
      rv.ld   = $urandom_range(1);
      rv.rd   = regs[$urandom_range(2)];
      rv.bt   = 2'($urandom);
      rv.cd   = 4'($urandom);
      rv.rt   = regs[$urandom_range(2)];
      rv.dt   = ($urandom_range(1) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
      rv.e_tk = 1'b0; rv.e_st = 1'b0; rv.e_fq = 4'h0;
      applyStimulus(rv);
      checkOutput("rand br_taken", 64'(s_tk), 64'(m_exp_tk));
      checkOutput("rand stall", 64'(s_st), 64'(m_exp_st));
      checkOutput("rand flags_q", 64'(flags_q), 64'(m_flags));
`ifdef BRANCH_STATS_EN
      checkOutput("rand br_count", 64'(br_count), 64'(m_br_cnt));
      checkOutput("rand taken_count", 64'(taken_count), 64'(m_tk_cnt));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
